// File: rtl/fft_pkg.sv
// Shared 8-point FFT definitions: frame geometry, loader FSM states and address bit reversal.
package fft_pkg;

  localparam int unsigned FFT_N_PTS  = 8;
  localparam int unsigned FFT_ADDR_W = 3;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } loader_state_e;

  function automatic logic [FFT_ADDR_W-1:0] bitrev3(input logic [FFT_ADDR_W-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/fft_input_loader_8pt.sv
// Streams complex samples into the 8-sample FFT buffer at bit-reversed addresses and hands full frames to the engine.
// Optional in_last framing checks are enabled with FFT_LOADER_LAST_CHECK_EN.
module fft_input_loader_8pt
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_PTS  = FFT_N_PTS,
  parameter int unsigned ADDR_W = FFT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_real,
  output logic [DATA_W-1:0] wr_imag,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic [7:0]        frame_cnt,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PTS - 1);

  loader_state_e     state, state_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic              commit_q, commit_d;
  logic              in_ready_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_real_d, wr_imag_d;
  logic              frame_valid_d;
  logic [7:0]        frame_cnt_d;
  logic              xfer_c;

`ifdef FFT_LOADER_LAST_CHECK_EN
  logic miss_q, miss_d;
  logic frame_err_d;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign frame_err      = 1'b0;
`endif

  assign xfer_c = in_valid && in_ready;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    commit_d      = 1'b0;
    in_ready_d    = in_ready;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr;
    wr_real_d     = wr_real;
    wr_imag_d     = wr_imag;
    frame_valid_d = frame_valid;
    frame_cnt_d   = frame_cnt;
`ifdef FFT_LOADER_LAST_CHECK_EN
    miss_d        = 1'b0;
    frame_err_d   = 1'b0;
`endif

    unique case (state)
      LOAD: begin
        in_ready_d = 1'b1;
        if (xfer_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = bitrev3(idx);
          wr_real_d = in_real;
          wr_imag_d = in_imag;
          if (idx == LAST_IDX) begin
            idx_d      = '0;
            state_d    = FULL;
            in_ready_d = 1'b0;
            commit_d   = 1'b1;
`ifdef FFT_LOADER_LAST_CHECK_EN
            miss_d     = !in_last;
`endif
          end else begin
            idx_d = idx + ADDR_W'(1);
`ifdef FFT_LOADER_LAST_CHECK_EN
            // Early in_last: keep the sample but restart the frame
            if (in_last) begin
              idx_d       = '0;
              frame_err_d = 1'b1;
            end
`endif
          end
        end
      end

      FULL: begin
        in_ready_d = 1'b0;
        // Commit one edge after the last write so the buffer is settled
        if (commit_q) begin
          frame_valid_d = 1'b1;
          frame_cnt_d   = frame_cnt + 8'd1;
`ifdef FFT_LOADER_LAST_CHECK_EN
          frame_err_d   = miss_q;
`endif
        end else if (frame_valid && frame_ack) begin
          frame_valid_d = 1'b0;
          in_ready_d    = 1'b1;
          state_d       = LOAD;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      idx         <= '0;
      commit_q    <= 1'b0;
      in_ready    <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_real     <= '0;
      wr_imag     <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      commit_q    <= commit_d;
      in_ready    <= in_ready_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_real     <= wr_real_d;
      wr_imag     <= wr_imag_d;
      frame_valid <= frame_valid_d;
      frame_cnt   <= frame_cnt_d;
    end
  end

`ifdef FFT_LOADER_LAST_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      miss_q    <= miss_d;
      frame_err <= frame_err_d;
    end
  end
`endif

endmodule
